simon_decrypt_iter: RTL
=======================

Name: simon_decrypt_iter

Overview:
- Iterative, single-direction Simon decryption core: one round per clock.
- Parameterised over all ten Simon block/key variants.
- Expands the master key into a cached round-key array, then applies rounds from T-1 down to 0.
- Sits as the receive-side counterpart to the encryption datapath, between an input ciphertext handshake and an output plaintext handshake.

Parameters:
- N, 16, word size in bits (16/24/32/48/64).
- M, 4, key words (2/3/4).
- T, 32, round count.
- j, 0, z-sequence index (0..4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ciphertext/key offered.
- in_ready  out  1  core can accept.
- key_new  in  1  1 = expand the supplied key; 0 = reuse the cached schedule.
- din  in  2N  ciphertext {x,y}, x in upper N bits.
- key  in  M*N  master key {k[M-1],...,k[0]}, k[0] in low N bits.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  downstream accepts.
- dout  out  2N  plaintext {x,y}.
- busy  out  1  high in EXPAND or DECRYPT.

Behaviour:
- Reset values (asynchronous, active-high): in_ready=1, out_valid=0, busy=0, dout=0, state=IDLE, sched_ok=0. Round-key array need not be cleared.
- States: IDLE, EXPAND, DECRYPT, OUT.
- IDLE, accept condition: in_valid & in_ready. On accept:
  - latch din into (x,y).
  - in_ready falls next cycle.
  - If key_new=1 or sched_ok=0: write rk[0..M-1] from key, set counter i=M, go to EXPAND.
  - Otherwise: set r=T-1, go to DECRYPT.
  - key_new=0 with sched_ok=0 is forced to expand; the supplied key is used.
- EXPAND (T-M cycles): each cycle write rk[i] using the Simon schedule, with c = 2^N-4 and z = z_j[(i-M) mod 62]:
  - M=2: tmp = ROR3(rk[i-1]).
  - M=3: tmp = ROR3(rk[i-1]).
  - M=4: tmp = ROR3(rk[i-1]) ^ rk[i-3].
  - All M: tmp ^= ROR1(tmp); rk[i] = ~rk[i-M] ^ tmp ^ z ^ 3.
  - This is equivalent to c ^ z ^ rk[i-M] ^ tmp.
  - Advance i. After writing rk[T-1]: set sched_ok=1, r=T-1, go to DECRYPT.
- DECRYPT (T cycles): each cycle
  - x' = y.
  - y' = x ^ ((ROL1 y) & (ROL8 y)) ^ ROL2 y ^ rk[r].
  - Decrement r. After the r=0 round, go to OUT.
- OUT:
  - out_valid=1, dout={x,y}.
  - dout is held stable while out_valid & ~out_ready.
  - On out_ready: out_valid=0, in_ready=1, go to IDLE.
  - A new accept cannot occur in the same cycle as the OUT handshake.
- Latency from the accept edge to out_valid high: 2T-M edges with expansion (60 for 32/64, 140 for 128/256); T edges with reuse.
- Inputs are ignored when in_ready=0. din and key may change freely after accept.
- z_j is a 62-bit constant table. Rotations are modulo N. All arithmetic is XOR/AND on N-bit words; no carries.
- Reset mid-operation: the operation is abandoned, no out_valid is produced, and sched_ok=0, so the next request always expands.
- The last cycle of DECRYPT and out_ready have no interaction; out_ready is sampled only in OUT.

Test Plan:
- 32/64: din=32'hc69be9bb, key=64'h1918111009080100, key_new=1, out_ready=1 -> dout=32'h65656877; out_valid 60 cycles after accept; in_ready low throughout.
- 128/256 (N=64,M=4,T=72,j=4): din=128'h8d2b5579afc8a3a03bf72a87efe7b868, key=256'h1f1e...0100 -> dout=128'h74206e69206d6f6f6d69732061207369 after 140 cycles.
- Key reuse: repeat the 32/64 vector with key_new=0 and key=0 -> identical dout after 32 cycles; busy high exactly 32 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid and dout stable, in_ready=0, in_valid pulses ignored; release -> one-cycle handshake, then in_ready=1.
- Reset mid-DECRYPT (cycle 40 of 60): assert rst -> out_valid=0, in_ready=1 immediately. Next request with key_new=0 -> core still takes the 60-cycle expand path and produces the correct plaintext.
- Back-to-back: two different ciphertexts under the same key, with in_valid held high -> both decrypted in order; no accept while busy.

Source files
------------

// File: rtl/simon_decrypt_iter_if.sv
// Handshake bundle for the iterative Simon decryption core: ciphertext/key in,
// plaintext out. The core takes the slave view.
interface simon_decrypt_iter_if #(
    parameter int N = 16,
    parameter int M = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic             key_new;
    logic [2*N-1:0]   din;
    logic [M*N-1:0]   key;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   dout;
    logic             busy;

    modport master (
        output in_valid, key_new, din, key, out_ready,
        input  in_ready, out_valid, dout, busy
    );

    modport slave (
        input  in_valid, key_new, din, key, out_ready,
        output in_ready, out_valid, dout, busy
    );
endinterface

// File: rtl/simon_decrypt_iter.sv
// Iterative Simon decryption: expands and caches the round keys, then runs
// one inverse round per clock from round T-1 down to round 0.
module simon_decrypt_iter #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32,
    parameter int j = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    simon_decrypt_iter_if.slave  bus
);
    localparam int AW = $clog2(T);

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, OUT} state_e;

    // z sequences stored LSB-first, so bit k is the k-th element of z_j.
    localparam logic [4:0][61:0] Z_TAB = {
        62'b11110111001001010011000011101000000100011011010110011110001011,
        62'b11110000101100111001010001001000000111101001100011010111011011,
        62'b11001101101001111110001000010100011001001011000000111011110101,
        62'b01011010000110010011111011100010101101000011001001111101110001,
        62'b01100111000011010100100010111110110011100001101010010001011111
    };
    localparam logic [61:0] Z_SEQ = Z_TAB[j];

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
        return (v >> s) | (v << (N - s));
    endfunction

    state_e           state_q, state_d;
    logic [N-1:0]     x_q, x_d, y_q, y_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [5:0]       zi_q, zi_d;
    logic             sched_ok_q, sched_ok_d;
    logic [2*N-1:0]   dout_q, dout_d;

    logic [N-1:0]     rk_mem [T];
    logic             key_load, rk_we;
    logic [N-1:0]     rk_tmp, rk_mix, rk_new, round_y;

    // cnt_q is the schedule write index in EXPAND and the round index in DECRYPT.
    if (M == 4) begin : g_m4
        assign rk_tmp = ror(rk_mem[cnt_q - AW'(1)], 3) ^ rk_mem[cnt_q - AW'(3)];
    end else begin : g_m23
        assign rk_tmp = ror(rk_mem[cnt_q - AW'(1)], 3);
    end

    assign rk_mix  = rk_tmp ^ ror(rk_tmp, 1);
    assign rk_new  = ~rk_mem[cnt_q - AW'(M)] ^ rk_mix ^ N'(Z_SEQ[zi_q]) ^ N'(3);
    assign round_y = x_q ^ (rol(y_q, 1) & rol(y_q, 8)) ^ rol(y_q, 2) ^ rk_mem[cnt_q];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        zi_d       = zi_q;
        sched_ok_d = sched_ok_q;
        dout_d     = dout_q;
        key_load   = 1'b0;
        rk_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d = bus.din[2*N-1:N];
                    y_d = bus.din[N-1:0];
                    if (bus.key_new || !sched_ok_q) begin
                        key_load = 1'b1;
                        cnt_d    = AW'(M);
                        zi_d     = '0;
                        state_d  = EXPAND;
                    end else begin
                        cnt_d    = AW'(T - 1);
                        state_d  = DECRYPT;
                    end
                end
            end
            EXPAND: begin
                rk_we = 1'b1;
                zi_d  = (zi_q == 6'd61) ? 6'd0 : zi_q + 6'd1;
                if (cnt_q == AW'(T - 1)) begin
                    sched_ok_d = 1'b1;
                    state_d    = DECRYPT;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            DECRYPT: begin
                x_d = y_q;
                y_d = round_y;
                if (cnt_q == '0) begin
                    dout_d  = {y_q, round_y};
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q - AW'(1);
                end
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            zi_q       <= '0;
            sched_ok_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            zi_q       <= zi_d;
            sched_ok_q <= sched_ok_d;
            dout_q     <= dout_d;
        end
    end

    // NOTE: the round-key array has no reset; sched_ok_q guards any stale contents.
    always_ff @(posedge clk) begin
        if (key_load) begin
            for (int k = 0; k < M; k++) rk_mem[AW'(k)] <= N'(bus.key >> (k * N));
        end else if (rk_we) begin
            rk_mem[cnt_q] <= rk_new;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.busy      = (state_q == EXPAND) || (state_q == DECRYPT);
    assign bus.dout      = dout_q;
endmodule
